// File: rtl/fpmul_share_arbiter.sv
// Round-robin sharing of one 4-phase serial-operand FP32 multiplier among NREQ
// requesters; products return through a small FIFO tagged with the requester ID.
module fpmul_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int RES_DEPTH = 2
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_opa,
  input  logic [NREQ*32-1:0]  req_opb,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [31:0]         res_data,
  output logic [IDW-1:0]      res_id,
  output logic [31:0]         mul_a,
  input  logic [31:0]         mul_product,
  input  logic                mul_ready,
  output logic                busy,
  output logic                sync_err
);
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = $clog2(RES_DEPTH + 1);

  typedef struct packed {
    logic [31:0]    data;
    logic [IDW-1:0] id;
  } res_t;

  logic [NREQ-1:0][31:0] opa_v, opb_v;
  assign opa_v = req_opa;
  assign opb_v = req_opb;

  logic [1:0]     ph;
  logic           ph0;
  logic           inflight;
  logic [31:0]    hold_a, hold_b;
  logic [IDW-1:0] hold_id, rr;

  res_t           fifo_q [RES_DEPTH];
  res_t           head;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  occ;

  logic           credit_ok, hs, push, pop;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] win;
  logic [31:0]    sel_a, sel_b;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ph0 = (ph == 2'd0);
  // A grant reserves a FIFO slot up front; a pop on the same edge is not credited.
  assign credit_ok = ({1'b0, occ} + (CW+1)'(inflight)) < (CW+1)'(RES_DEPTH);

  // Scan offsets farthest-first so the nearest requester after rr overwrites last.
  always_comb begin
    grant = '0;
    win   = '0;
    sel_a = '0;
    sel_b = '0;
    if (ph0 && credit_ok) begin
      for (int k = NREQ; k >= 1; k--) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i == (int'(rr) + k) % NREQ && req_valid[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            win      = IDW'(i);
            sel_a    = opa_v[i];
            sel_b    = opb_v[i];
          end
        end
      end
    end
  end

  assign hs        = |grant;
  assign push      = ph0 && inflight && mul_ready;
  assign pop       = res_valid && res_ready;
  assign req_ready = grant & {NREQ{nreset}};

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ph       <= 2'd0;
      inflight <= 1'b0;
      hold_a   <= '0;
      hold_b   <= '0;
      hold_id  <= '0;
      rr       <= IDW'(NREQ - 1);
      sync_err <= 1'b0;
    end else begin
      ph <= ph + 2'd1;
      if (hs) begin
        hold_a   <= sel_a;
        hold_b   <= sel_b;
        hold_id  <= win;
        rr       <= win;
        inflight <= 1'b1;
      end else if (ph0) begin
        inflight <= 1'b0;
      end
      // Product strobe outside R, or missing in R of a live slot: phases have slipped.
      if ((!ph0 && mul_ready) || (ph0 && inflight && !mul_ready))
        sync_err <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < RES_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{data: mul_product, id: hold_id};
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      occ <= occ + CW'(1);
      else if (pop && !push) occ <= occ - CW'(1);
    end
  end

  assign head      = fifo_q[rd_ptr];
  assign res_valid = (occ != '0);
  assign res_data  = res_valid ? head.data : '0;
  assign res_id    = res_valid ? head.id : '0;

  // The slot is live exactly while inflight is set, so busy reduces to it.
  assign mul_a = !inflight     ? '0 :
                 (ph == 2'd1)  ? hold_a :
                 (ph == 2'd2)  ? hold_b : '0;
  assign busy  = inflight;

endmodule

// File: doc/fpmul_share_arbiter.md
Name: fpmul_share_arbiter

Overview:
- Shares one serial-operand FP32 multiplier among NREQ requesters, each presenting a full operand pair {opa, opb}.
- Round-robin arbitration; drives the multiplier's single 32-bit operand bus in its fixed 4-phase cycle (R, A, B, C).
- Captures each product into a small result FIFO, tagged with the requester ID.
- Sits between the posit/FP test clients and the FP32 multiplier core. Shares that core's clock and nreset.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of res_id; must be at least clog2(NREQ)
- RES_DEPTH, 2, result FIFO entries (at least 2)

Ports:
- clock  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand pair valid
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] and req_ready[i] are both high
- req_opa  in  NREQ*32  operand A, requester i at bits [32i+31:32i]
- req_opb  in  NREQ*32  operand B, same packing
- res_valid  out  1  result FIFO head valid
- res_ready  in  1  consumer accepts head
- res_data  out  32  product (FIFO head)
- res_id  out  IDW  requester index of head
- mul_a  out  32  multiplier operand bus
- mul_product  in  32  multiplier product
- mul_ready  in  1  multiplier product-valid strobe
- busy  out  1  a transaction is in flight
- sync_err  out  1  sticky phase-mismatch flag

Behaviour:
- Reset (async, nreset low):
  - ph=0, inflight=0, FIFO empty, rr pointer=NREQ-1, sync_err=0.
  - All outputs 0: req_ready=0, res_valid=0, res_data=0, res_id=0, mul_a=0, busy=0.
- Phase counter ph (2 bits):
  - Increments mod 4 every clock from reset.
  - ph 0/1/2/3 mirror multiplier states R/A/B/C.
  - No other phase alignment exists: the arbiter and multiplier must leave reset on the same edge.
- Grant (combinational, only when ph==0):
  - Candidates are requesters with req_valid high.
  - Search starts at rr+1 and wraps.
  - Grant allowed only if occupancy + inflight < RES_DEPTH (conservative; a same-cycle pop is not credited).
  - req_ready is one-hot for the winner, else all 0. req_ready is 0 whenever ph!=0.
- On the handshake edge:
  - Latch opa, opb and the winner ID into the hold registers.
  - Set rr=winner and inflight_next=1.
- mul_a drive:
  - ph==1: hold opa.
  - ph==2: hold opb.
  - Otherwise: 0.
  - Also 0 when the slot is idle (no grant at the preceding ph0).
- Result capture:
  - In ph==0 with inflight=1, mul_ready must be 1.
  - Push {mul_product, id} into the FIFO at that edge; inflight clears unless a new grant sets it on the same edge.
- Latency: res_valid rises 4 cycles after the handshake edge (empty FIFO). Throughput: 1 op per 4 cycles.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Pop when res_valid && res_ready.
  - Push and pop may occur on the same edge; occupancy stays unchanged.
  - Overflow is impossible by the credit rule.
  - res_data, res_id and res_valid come from the head register, so there is no combinational path from mul_*.
- busy = inflight | (ph!=0 && slot active).
- sync_err is set and held until reset when either occurs:
  - mul_ready is 1 while ph!=0;
  - mul_ready is 0 in ph==0 while inflight=1. In this case the push is skipped and inflight clears.
- Special values (zero, inf, NaN) pass through unchanged. The arbiter never inspects operands.
- Reset mid-operation: in-flight and FIFO contents are discarded; no spurious res_valid after release.

Test Plan:
- Single op, requester 2: opa=0x40000000, opb=0x40400000 at ph0. Expect req_ready=4'b0100 for one cycle, mul_a=0x40000000 then 0x40400000, and 4 cycles later res_valid=1, res_data=0x40C00000, res_id=2.
- All four req_valid held high from reset, res_ready=1. Expect grant order 0,1,2,3,0 at 4-cycle spacing, res_id sequence matching, sync_err=0.
- res_ready=0 with 3 requests pending. Expect exactly 2 results buffered, then no req_ready; raising res_ready drains in order and granting resumes at the next ph0.
- Push/pop on the same edge with FIFO at 1 entry. Expect occupancy to stay 1 and the FIFO pointers to wrap correctly after 5 ops.
- Force mul_ready=1 in ph==2. Expect sync_err=1 next cycle, held until nreset.
- Assert nreset low during ph==2 of an op. Expect all outputs 0 immediately; after release, no res_valid until a new handshake plus 4 cycles.
